// File: rtl/adxl355_sync_gen.sv
// 1 kHz ADXL355 sync strobe generator, phase-aligned to GPS PPS, with PPS lock tracking.
// Define ADXL355_SYNC_PHASE_EN to capture the divider phase on every PPS edge (o_phase/o_phase_valid).
module adxl355_sync_gen #(
  parameter int clk_out0_hz = 40000000,
  parameter int sync_hz     = 1000,
  parameter int pps_tol_clk = 4000,
  parameter int lock_count  = 3,
  parameter int period_bits = 28
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pps,
  output logic                   o_clk_sync,
  output logic [9:0]             o_ms,
  output logic                   o_pps_lock,
  output logic [period_bits-1:0] o_phase,
  output logic                   o_phase_valid
);

  localparam int DIV   = clk_out0_hz / sync_hz;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int GC_W  = $clog2(lock_count + 1);

  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]       HALF    = CNT_W'(DIV / 2);
  localparam logic [9:0]             MS_MAX  = 10'(sync_hz - 1);
  localparam logic [GC_W-1:0]        GC_LOCK = GC_W'(lock_count);
  localparam logic [period_bits-1:0] PER_NOM = period_bits'(clk_out0_hz);
  localparam logic [period_bits-1:0] PER_TOL = period_bits'(pps_tol_clk);
  localparam logic [period_bits-1:0] PER_MAX = period_bits'(clk_out0_hz + pps_tol_clk);

  logic                   pps_s1_q, pps_s1_d;
  logic                   pps_s2_q, pps_s2_d;
  logic                   pps_s3_q, pps_s3_d;
  logic                   pps_edge_q, pps_edge_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       since_q, since_d;
  logic                   sync_q, sync_d;
  logic [9:0]             ms_q, ms_d;
  logic [period_bits-1:0] per_q, per_d;
  logic                   per_seen_q, per_seen_d;
  logic [GC_W-1:0]        good_cnt_q, good_cnt_d;
  logic                   lock_q, lock_d;

  logic [period_bits-1:0] per_diff;
  logic                   good;
  logic                   realign;
  logic                   wrap;

  always_comb begin
    pps_s1_d   = i_pps;
    pps_s2_d   = pps_s1_q;
    pps_s3_d   = pps_s2_q;
    pps_edge_d = pps_s2_q & ~pps_s3_q;

    per_diff = (per_q >= PER_NOM) ? (per_q - PER_NOM) : (PER_NOM - per_q);
    // The first edge after reset has no preceding edge, so its count is not a period.
    good     = pps_edge_q & per_seen_q & (per_diff <= PER_TOL);
    realign  = pps_edge_q & (good | ~lock_q);
    wrap     = (cnt_q == CNT_MAX);

    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    sync_d     = wrap;
    per_d      = (&per_q) ? per_q : per_q + 1'b1;
    per_seen_d = per_seen_q;
    good_cnt_d = good_cnt_q;
    lock_d     = lock_q;

    if (pps_edge_q) begin
      per_d      = period_bits'(1);
      per_seen_d = 1'b1;
      if (good) begin
        if (good_cnt_q != GC_LOCK) good_cnt_d = good_cnt_q + 1'b1;
        if (good_cnt_d == GC_LOCK) lock_d = 1'b1;
      end else begin
        good_cnt_d = '0;
        lock_d     = 1'b0;
      end
    end else if (per_q > PER_MAX) begin
      good_cnt_d = '0;
      lock_d     = 1'b0;
    end

    // A late PPS must not squeeze a strobe in right after the previous one.
    if (realign) begin
      cnt_d  = '0;
      sync_d = (since_q >= HALF);
    end

    if (realign)     ms_d = '0;
    else if (sync_d) ms_d = (ms_q == MS_MAX) ? '0 : ms_q + 10'd1;
    else             ms_d = ms_q;

    since_d = sync_d ? '0 : ((since_q >= HALF) ? since_q : since_q + 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pps_s1_q   <= 1'b0;
      pps_s2_q   <= 1'b0;
      pps_s3_q   <= 1'b0;
      pps_edge_q <= 1'b0;
      cnt_q      <= '0;
      since_q    <= '0;
      sync_q     <= 1'b0;
      ms_q       <= '0;
      per_q      <= '0;
      per_seen_q <= 1'b0;
      good_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      pps_s1_q   <= pps_s1_d;
      pps_s2_q   <= pps_s2_d;
      pps_s3_q   <= pps_s3_d;
      pps_edge_q <= pps_edge_d;
      cnt_q      <= cnt_d;
      since_q    <= since_d;
      sync_q     <= sync_d;
      ms_q       <= ms_d;
      per_q      <= per_d;
      per_seen_q <= per_seen_d;
      good_cnt_q <= good_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign o_clk_sync = sync_q;
  assign o_ms       = ms_q;
  assign o_pps_lock = lock_q;

`ifdef ADXL355_SYNC_PHASE_EN
  logic [period_bits-1:0] phase_q, phase_d;
  logic                   phase_valid_q, phase_valid_d;

  always_comb begin
    phase_d       = phase_q;
    phase_valid_d = pps_edge_q;
    if (pps_edge_q) phase_d = period_bits'(cnt_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  assign o_phase       = phase_q;
  assign o_phase_valid = phase_valid_q;
`else
  assign o_phase       = '0;
  assign o_phase_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adxl355_sync_gen.sv
// Bench for adxl355_sync_gen, scaled to clk_out0_hz=4000, sync_hz=100 (DIV=40, PPS period 4000,
// tolerance 4, lock after 3 good periods) so every scenario fits a short run.
module tb_adxl355_sync_gen;

  localparam int DIV = 40;
  localparam int PER = 4000;

  logic        clk;
  logic        i_rst;
  logic        i_pps;
  logic        o_clk_sync;
  logic [9:0]  o_ms;
  logic        o_pps_lock;
  logic [27:0] o_phase;
  logic        o_phase_valid;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    int d;          // cycles after a strobe at which PPS rises
    int exp_sync;   // strobe expected on the realign cycle
    int exp_phase;  // divider count seen on the edge cycle
  } align_vec_t;

  align_vec_t vecs [6];

  adxl355_sync_gen #(
    .clk_out0_hz(4000),
    .sync_hz    (100),
    .pps_tol_clk(4),
    .lock_count (3),
    .period_bits(28)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_pps        (i_pps),
    .o_clk_sync   (o_clk_sync),
    .o_ms         (o_ms),
    .o_pps_lock   (o_pps_lock),
    .o_phase      (o_phase),
    .o_phase_valid(o_phase_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: cycle %0d reached, required end of test", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_phase(input string name, input int exp);
    int ev;
    int ee;
    ev = 1;
    ee = exp;
`ifndef ADXL355_SYNC_PHASE_EN
    ev = 0;
    ee = 0;
`endif
    chk({name, "_vld"}, int'(o_phase_valid), ev);
    chk(name, int'(o_phase), ee);
  endtask

  // Raise PPS so that the realign takes effect exactly at cycle act_cyc.
  task automatic pps_act(input int act_cyc);
    run_to(act_cyc - 4);
    i_pps = 1'b1;
    repeat (4) step();
    i_pps = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_clk_sync && n < 100);
  endtask

  initial begin
    int n;
    int base;
    int b3;
    int b4;
    int b7;
    int b8;

    vecs[0] = '{d: 0,  exp_sync: 0, exp_phase: 3};
    vecs[1] = '{d: 16, exp_sync: 0, exp_phase: 19};
    vecs[2] = '{d: 17, exp_sync: 1, exp_phase: 20};
    vecs[3] = '{d: 27, exp_sync: 1, exp_phase: 30};
    vecs[4] = '{d: 36, exp_sync: 1, exp_phase: 39};
    vecs[5] = '{d: 37, exp_sync: 0, exp_phase: 0};

    checks = 0;
    errors = 0;
    cyc    = 0;
    i_rst  = 1'b1;
    i_pps  = 1'b0;
    repeat (3) step();
    i_rst = 1'b0;
    cyc   = 0;

    chk("rst_sync", int'(o_clk_sync), 0);
    chk("rst_ms", int'(o_ms), 0);
    chk("rst_lock", int'(o_pps_lock), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_phase_vld", int'(o_phase_valid), 0);

    // Free-running without PPS: one strobe per DIV, ms index wraps 99 -> 0.
    for (int j = 1; j <= 101; j++) begin
      wait_strobe(n);
      chk($sformatf("free_gap%0d", j), n, DIV);
      chk($sformatf("free_ms%0d", j), int'(o_ms), j % 100);
    end
    chk("free_lock", int'(o_pps_lock), 0);

    // Unlocked realign at various divider phases.
    for (int i = 0; i < 6; i++) begin
      pps_act(cyc + vecs[i].d + 4);
      chk($sformatf("align%0d_sync", i), int'(o_clk_sync), vecs[i].exp_sync);
      chk($sformatf("align%0d_ms", i), int'(o_ms), 0);
      chk($sformatf("align%0d_lock", i), int'(o_pps_lock), 0);
      chk_phase($sformatf("align%0d_phase", i), vecs[i].exp_phase);
      wait_strobe(n);
      chk($sformatf("align%0d_gap", i), n, DIV);
    end

    // Acquisition: four edges one nominal period apart.
    base = cyc + 4;
    pps_act(base);
    chk("acq0_sync", int'(o_clk_sync), 0);
    chk("acq0_ms", int'(o_ms), 0);
    chk("acq0_lock", int'(o_pps_lock), 0);
    for (int k = 1; k <= 3; k++) begin
      pps_act(base + PER * k);
      chk($sformatf("acq%0d_sync", k), int'(o_clk_sync), 1);
      chk($sformatf("acq%0d_ms", k), int'(o_ms), 0);
      chk($sformatf("acq%0d_lock", k), int'(o_pps_lock), (k == 3) ? 1 : 0);
    end
    b3 = base + 3 * PER;

    // Late PPS: lock drops at the timeout, late edge realigns unlocked.
    run_to(b3 + 4004);
    chk("late_lock_hold", int'(o_pps_lock), 1);
    step();
    chk("late_lock_drop", int'(o_pps_lock), 0);
    b4 = b3 + 4010;
    pps_act(b4);
    chk("late_sync", int'(o_clk_sync), 0);
    chk("late_ms", int'(o_ms), 0);
    chk("late_lock", int'(o_pps_lock), 0);
    chk_phase("late_phase", 9);
    run_to(b4 + 39);
    chk("late_pre_sync", int'(o_clk_sync), 0);
    step();
    chk("late_next_sync", int'(o_clk_sync), 1);
    chk("late_next_ms", int'(o_ms), 1);
    for (int k = 1; k <= 3; k++) begin
      pps_act(b4 + PER * k);
      chk($sformatf("relock%0d_sync", k), int'(o_clk_sync), 1);
      chk($sformatf("relock%0d_ms", k), int'(o_ms), 0);
      chk($sformatf("relock%0d_lock", k), int'(o_pps_lock), (k == 3) ? 1 : 0);
    end
    b7 = b4 + 3 * PER;

    // Glitch while locked: no realign, lock lost, grid unchanged.
    pps_act(b7 + 1010);
    chk("glitch_sync", int'(o_clk_sync), 0);
    chk("glitch_ms", int'(o_ms), 25);
    chk("glitch_lock", int'(o_pps_lock), 0);
    chk_phase("glitch_phase", 9);
    run_to(b7 + 1040);
    chk("glitch_grid_sync", int'(o_clk_sync), 1);
    chk("glitch_grid_ms", int'(o_ms), 26);
    b8 = b7 + PER;
    pps_act(b8);
    chk("postglitch_sync", int'(o_clk_sync), 1);
    chk("postglitch_ms", int'(o_ms), 0);
    chk("postglitch_lock", int'(o_pps_lock), 0);
    for (int k = 1; k <= 3; k++) begin
      pps_act(b8 + PER * k);
      chk($sformatf("glock%0d_lock", k), int'(o_pps_lock), (k == 3) ? 1 : 0);
      chk($sformatf("glock%0d_sync", k), int'(o_clk_sync), 1);
    end

    // Reset in the middle of locked operation.
    run_to(b8 + 3 * PER + 13);
    i_rst = 1'b1;
    step();
    chk("mrst_sync", int'(o_clk_sync), 0);
    chk("mrst_ms", int'(o_ms), 0);
    chk("mrst_lock", int'(o_pps_lock), 0);
    chk("mrst_phase", int'(o_phase), 0);
    chk("mrst_phase_vld", int'(o_phase_valid), 0);
    i_rst = 1'b0;
    cyc   = 0;
    wait_strobe(n);
    chk("mrst_gap", n, DIV);
    chk("mrst_first_ms", int'(o_ms), 1);
    chk("mrst_lock_after", int'(o_pps_lock), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
